// File: rtl/mio_bus_responder.sv
// MIO bus responder: wait-stated, lane-masked word RAM serving CPU loads/stores with a one-cycle ready pulse.
// Optional build macro MIO_MISALIGN_CHK_EN flags misaligned half/word accesses as errors instead of forcing alignment.
module mio_bus_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_MIO,
  input  logic        MemRW,
  input  logic [2:0]  Length,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        mio_busy,
  output logic        mio_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_armed;
  logic [AW+1:0]     r_addr;
  logic              r_rw;
  logic [2:0]        r_len;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic              r_err;
  logic [3:0][7:0]   r_mem [DEPTH_WORDS];

  logic              w_accept, w_illegal, w_mis, w_err, w_we;
  logic              w_byte, w_half, w_word;
  logic [AW-1:0]     w_idx;
  logic [3:0][7:0]   w_rword;
  logic [3:0][7:0]   w_wword;
  logic [3:0]        w_be;
  logic [7:0]        w_b;
  logic [15:0]       w_h;
  logic [31:0]       w_ldata;

  assign w_accept = (r_state == IDLE) && CPU_MIO && r_armed;
  assign w_idx    = r_addr[AW+1:2];
  assign w_rword  = r_mem[w_idx];
  assign w_byte   = (r_len[2:1] == 2'b00);
  assign w_half   = (r_len[2:1] == 2'b01);
  assign w_word   = (r_len == 3'b100);

  // Stores only know unsigned sizes; loads reject the three codes above lw.
  assign w_illegal = r_rw ? !(r_len == 3'b000 || r_len == 3'b010 || r_len == 3'b100)
                          : (r_len > 3'b100);
`ifdef MIO_MISALIGN_CHK_EN
  assign w_mis = (w_half && r_addr[0]) || (w_word && (r_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif
  assign w_err = w_illegal || w_mis;
  assign w_we  = (r_state == ACCESS) && r_rw && !w_err && rst_n;

  always_comb begin
    w_wword = Data_out;
    w_be    = 4'b0000;
    w_wword = r_wdata;
    if (w_byte) begin
      w_wword = {4{r_wdata[7:0]}};
      w_be    = 4'b0001 << r_addr[1:0];
    end else if (w_half) begin
      w_wword = {2{r_wdata[15:0]}};
      w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
    end else if (w_word) begin
      w_be    = 4'b1111;
    end
  end

  always_comb begin
    w_b     = w_rword[r_addr[1:0]];
    w_h     = r_addr[1] ? {w_rword[3], w_rword[2]} : {w_rword[1], w_rword[0]};
    w_ldata = 32'd0;
    if (!w_err) begin
      case (r_len)
        3'b000:  w_ldata = {24'd0, w_b};
        3'b001:  w_ldata = {{24{w_b[7]}}, w_b};
        3'b010:  w_ldata = {16'd0, w_h};
        3'b011:  w_ldata = {{16{w_h[15]}}, w_h};
        3'b100:  w_ldata = w_rword;
        default: w_ldata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_len   <= 3'd0;
      r_wdata <= 32'd0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_armed <= 1'b0;
        r_cnt   <= CNT_INIT;
        r_addr  <= Addr_in[AW+1:0];
        r_rw    <= MemRW;
        r_len   <= Length;
        r_wdata <= Data_out;
      end else begin
        if (!CPU_MIO) r_armed <= 1'b1;
        if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ACCESS) begin
        r_err <= w_err;
        if (!r_rw || w_err) r_data <= w_ldata;
      end else if (r_state == RESP) begin
        r_err <= 1'b0;
      end
    end
  end

  // RAM has no reset; w_we already excludes a store caught by reset at its edge.
  always_ff @(posedge clk)
    if (w_we)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][i] <= w_wword[i];

  assign Data_in   = r_data;
  assign MIO_ready = (r_state == RESP);
  assign mio_busy  = (r_state != IDLE);
  assign mio_err   = r_err;
endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance for latency.
module tb_mio_bus_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu, cpu0, rw;
  logic [2:0]  len;
  logic [31:0] addr, wdata;
  logic [31:0] din, din0;
  logic        rdy, rdy0, busy, busy0, err, err0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mio_bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(cpu), .MemRW(rw), .Length(len),
    .Addr_in(addr), .Data_out(wdata), .Data_in(din), .MIO_ready(rdy),
    .mio_busy(busy), .mio_err(err));

  mio_bus_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(cpu0), .MemRW(rw), .Length(len),
    .Addr_in(addr), .Data_out(wdata), .Data_in(din0), .MIO_ready(rdy0),
    .mio_busy(busy0), .mio_err(err0));

  // One request on the selected instance; lat counts negedges after the accepting edge, -1 on timeout.
  task automatic txn(input bit sel, input logic w, input logic [2:0] l, input logic [31:0] a,
                     input logic [31:0] wd, output int lat, output logic [31:0] d,
                     output logic e, output logic extra);
    bit seen = 0;
    lat = -1; d = 'x; e = 'x;
    @(negedge clk);
    rw = w; len = l; addr = a; wdata = wd;
    if (sel) cpu0 = 1'b1; else cpu = 1'b1;
    @(negedge clk);
    cpu = 1'b0; cpu0 = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      if (sel ? rdy0 : rdy) begin
        seen = 1; lat = n; d = sel ? din0 : din; e = sel ? err0 : err;
      end else @(negedge clk);
    end
    @(negedge clk);
    extra = sel ? rdy0 : rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu = 0; cpu0 = 0; rw = 0; len = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    n_tests++; if (din !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h exp 00000000", din); end
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", rdy); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] d; logic e, x;
    txn(0, 1, 3'b100, 32'h10, 32'hDEADBEEF, lat, d, e, x);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL sw_latency got %0d exp 4", lat); end
    n_tests++; if (x !== 1'b0) begin n_fail++; $display("FAIL sw_pulse_width got %b exp 0", x); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b exp 0", e); end
    txn(0, 0, 3'b100, 32'h10, 32'h0, lat, d, e, x);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL lw_latency got %0d exp 4", lat); end
    n_tests++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", d); end
    n_tests++; if (e !== 1'b0 || x !== 1'b0) begin n_fail++; $display("FAIL lw_err_pulse got %b%b exp 00", e, x); end
  endtask

  task automatic test_extension();
    int lat; logic [31:0] d; logic e, x;
    txn(0, 1, 3'b100, 32'h20, 32'h80F07F01, lat, d, e, x);
    txn(0, 0, 3'b001, 32'h23, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got %h exp ffffff80", d); end
    txn(0, 0, 3'b000, 32'h23, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h exp 00000080", d); end
    txn(0, 0, 3'b011, 32'h22, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'hFFFF80F0) begin n_fail++; $display("FAIL lh got %h exp ffff80f0", d); end
    txn(0, 0, 3'b010, 32'h20, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'h00007F01) begin n_fail++; $display("FAIL lhu got %h exp 00007f01", d); end
  endtask

  task automatic test_lanes();
    int lat; logic [31:0] d; logic e, x;
    txn(0, 1, 3'b100, 32'h30, 32'h11223344, lat, d, e, x);
    n_tests++; if (d !== 32'h00007F01) begin n_fail++; $display("FAIL store_keeps_data got %h exp 00007f01", d); end
    txn(0, 1, 3'b000, 32'h31, 32'h000000AA, lat, d, e, x);
    txn(0, 1, 3'b010, 32'h32, 32'h0000BBCC, lat, d, e, x);
    txn(0, 0, 3'b100, 32'h30, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'hBBCCAA44) begin n_fail++; $display("FAIL lane_mask got %h exp bbccaa44", d); end
  endtask

  task automatic test_handshake();
    int pulses, lat; logic [31:0] d; logic e, x;
    @(negedge clk);
    rw = 0; len = 3'b100; addr = 32'h10; cpu = 1'b1; pulses = 0;
    repeat (20) begin @(negedge clk); if (rdy) pulses++; end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL held_request_pulses got %0d exp 1", pulses); end
    cpu = 1'b0;
    @(negedge clk);
    cpu = 1'b1; pulses = 0;
    repeat (10) begin @(negedge clk); if (rdy) pulses++; end
    cpu = 1'b0;
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL rearm_pulses got %0d exp 1", pulses); end
    txn(1, 1, 3'b100, 32'h8, 32'hA5A5_5A5A, lat, d, e, x);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL w0_store_latency got %0d exp 2", lat); end
    txn(1, 0, 3'b100, 32'h8, 32'h0, lat, d, e, x);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL w0_load_latency got %0d exp 2", lat); end
    n_tests++; if (d !== 32'hA5A55A5A) begin n_fail++; $display("FAIL w0_load_data got %h exp a5a55a5a", d); end
  endtask

  task automatic test_reset_midop();
    int lat, pulses; logic [31:0] d; logic e, x;
    txn(0, 1, 3'b100, 32'h40, 32'h0, lat, d, e, x);
    txn(0, 0, 3'b100, 32'h30, 32'h0, lat, d, e, x);
    @(negedge clk);
    rw = 1; len = 3'b100; addr = 32'h40; wdata = 32'h12345678; cpu = 1'b1;
    @(negedge clk);
    cpu = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_wait got %b exp 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (din !== 32'd0 || busy !== 1'b0 || err !== 1'b0 || rdy !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset_outputs got %h/%b/%b/%b exp 00000000/0/0/0", din, busy, err, rdy);
    end
    @(negedge clk);
    rst_n = 1'b1; pulses = 0;
    repeat (8) begin @(negedge clk); if (rdy) pulses++; end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL ready_after_reset got %0d exp 0", pulses); end
    txn(0, 0, 3'b100, 32'h40, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'd0 || lat != 4) begin n_fail++; $display("FAIL store_discarded got %h lat %0d exp 00000000 lat 4", d, lat); end
  endtask

  task automatic test_misalign_illegal();
    int lat; logic [31:0] d, exp_d; logic e, x, exp_e;
    txn(0, 1, 3'b100, 32'h40, 32'hCAFEF00D, lat, d, e, x);
`ifdef MIO_MISALIGN_CHK_EN
    exp_e = 1'b1; exp_d = 32'h0;
`else
    exp_e = 1'b0; exp_d = 32'hCAFEF00D;
`endif
    txn(0, 0, 3'b100, 32'h42, 32'h0, lat, d, e, x);
    n_tests++; if (d !== exp_d || e !== exp_e) begin n_fail++; $display("FAIL misaligned_lw got %h/%b exp %h/%b", d, e, exp_d, exp_e); end
    if (!exp_e) exp_d = 32'hFFFFF00D;
    txn(0, 0, 3'b011, 32'h41, 32'h0, lat, d, e, x);
    n_tests++; if (d !== exp_d || e !== exp_e) begin n_fail++; $display("FAIL misaligned_lh got %h/%b exp %h/%b", d, e, exp_d, exp_e); end
    txn(0, 0, 3'b100, 32'h1040, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL addr_wrap got %h exp cafef00d", d); end
    txn(0, 0, 3'b111, 32'h40, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'd0 || e !== 1'b1) begin n_fail++; $display("FAIL illegal_load got %h/%b exp 00000000/1", d, e); end
    n_tests++; if (x !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_width got %b exp 0", x); end
    txn(0, 1, 3'b001, 32'h40, 32'h55555555, lat, d, e, x);
    n_tests++; if (e !== 1'b1 || lat != 4) begin n_fail++; $display("FAIL illegal_store got %b lat %0d exp 1 lat 4", e, lat); end
    txn(0, 0, 3'b100, 32'h40, 32'h0, lat, d, e, x);
    n_tests++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin n_fail++; $display("FAIL after_illegal_store got %h/%b exp cafef00d/0", d, e); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extension();
    test_lanes();
    test_handshake();
    test_reset_midop();
    test_misalign_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder serving the CPU side of the MIO handshake. It accepts a load/store request qualified by `CPU_MIO`, `MemRW` and the 3-bit `Length` code produced by the control decoder. It inserts a programmable number of wait states, performs a byte-lane-masked write or a sign/zero-extended read on an internal word RAM, and returns a one-cycle `MIO_ready` pulse. It sits between the datapath's memory stage and the data RAM/peripheral space.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, 4..65536.
- `WAIT_CYCLES`, 2: wait states inserted before the access; 0..15.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `CPU_MIO`  in  1  request, level-sensitive
- `MemRW`  in  1  1 = store, 0 = load
- `Length`  in  3  loads: 001 lb, 011 lh, 100 lw, 000 lbu, 010 lhu; stores: 000 sb, 010 sh, 100 sw
- `Addr_in`  in  32  byte address
- `Data_out`  in  32  store data from CPU, right-aligned
- `Data_in`  out  32  load result, extended to 32 bits
- `MIO_ready`  out  1  one-cycle completion pulse
- `mio_busy`  out  1  high whenever state ≠ IDLE
- `mio_err`  out  1  access error, valid together with `MIO_ready`

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE, accept condition: request is accepted when `CPU_MIO`=1 and `armed`=1.
  - On accept, `Addr_in`, `MemRW`, `Length` and `Data_out` are latched.
  - Next state is WAIT with cnt=`WAIT_CYCLES`-1, or ACCESS if `WAIT_CYCLES`=0.
- `armed` behaviour:
  - `armed` clears on accept.
  - `armed` sets in any cycle `CPU_MIO`=0.
  - A held-high request is therefore serviced once only; the requester must drop `CPU_MIO` for at least one cycle between requests.
- WAIT: if cnt=0, go to ACCESS; otherwise decrement cnt. Input changes are ignored (latched copies are used).
- ACCESS: word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (wrap modulo depth).
  - Store: byte writes lane addr[1:0] with `Data_out[7:0]`. Half writes lanes {addr[1],0} and {addr[1],1} with `Data_out[15:0]`. Word writes all lanes.
  - Load: selects the byte or half by addr[1:0] / addr[1], then sign-extends (lb, lh) or zero-extends (lbu, lhu). Result registers into `Data_in`.
  - Next state is RESP.
- Illegal `Length` codes: loads 101/110/111 and stores 001/011/101/110/111.
  - No RAM write; `Data_in` is loaded with 0; `mio_err`=1 in RESP.
- RESP: `MIO_ready`=1 for exactly this cycle; next state IDLE.
- `Data_in` holds its value until the next completed load or illegal access. Stores leave it unchanged.
- RAM contents are not reset.

## Timing
- Reset values: state IDLE, `MIO_ready`=0, `Data_in`=0, `mio_busy`=0, `mio_err`=0, `armed`=1, cnt=0.
- Accept at edge E0 → state ACCESS at edge E0+`WAIT_CYCLES` → state RESP at edge E0+`WAIT_CYCLES`+1.
  - `MIO_ready` is high for the cycle following that edge.
  - Total latency is `WAIT_CYCLES`+2 cycles from the accepting edge to the `MIO_ready` deassertion edge.
- A store is committed at the ACCESS edge. A load occurring in the cycle after RESP observes the new data.
- Next accept is possible at the edge following RESP, provided `armed` is set. Minimum request period is `WAIT_CYCLES`+3 cycles.
- `rst_n` low mid-operation (any state):
  - Immediate return to IDLE with all outputs at reset values.
  - A store not yet at its ACCESS edge is discarded.
  - A store at its ACCESS edge is discarded if `rst_n` is low at that edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MIO_MISALIGN_CHK_EN` defined:
  - Misaligned access = half with addr[0]=1, or word with addr[1:0]≠00.
  - A misaligned access performs no RAM write, loads `Data_in`=0, and asserts `mio_err`=1 with `MIO_ready`.
- `MIO_MISALIGN_CHK_EN` undefined:
  - addr[0] is ignored for halves; addr[1:0] is ignored for words (access is forced aligned).
  - `mio_err` reports illegal `Length` codes only.

## Test plan
- Store then load, `WAIT_CYCLES`=2: sw 0xDEADBEEF @0x10, then lw @0x10.
  - `MIO_ready` is a single pulse 4 cycles after each accept.
  - `Data_in`=0xDEADBEEF; `mio_err`=0.
- Byte/half extension, after sw 0x80F07F01 @0x20:
  - lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080.
  - lh @0x22 → 0xFFFF80F0; lhu @0x20 → 0x00007F01.
- Lane masking: sw 0x11223344 @0x30, sb 0xAA @0x31, sh 0xBBCC @0x32, then lw @0x30 → 0xBBCCAA44.
- Handshake: `CPU_MIO` held high for 20 cycles → exactly one `MIO_ready` pulse. Drop for 1 cycle and reassert → second pulse; `WAIT_CYCLES`=0 gives a 2-cycle latency.
- Reset mid-op: sw 0x12345678 @0x40 over prior 0; `rst_n` pulsed low during WAIT.
  - Outputs read 0 immediately; no `MIO_ready`.
  - Subsequent lw @0x40 → 0x00000000.
- Misaligned lw @0x42:
  - With macro: `mio_err`=1, `Data_in`=0.
  - Without macro: `mio_err`=0, `Data_in` = word @0x40. Illegal load `Length`=111 → `mio_err`=1 in both builds.
